// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side signal bundle for uart_tx_arbiter.
// The master modport is the arbiter; the slave modport is the clients plus the UART_TX status.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_idle;
  logic               busy;
  logic [2:0]         owner;
  logic               err_timeout;

  modport master (
    input  req, req_data, tx_idle,
    output grant, done, tx_data, tx_start, busy, owner, err_timeout
  );

  modport slave (
    output req, req_data, tx_idle,
    input  grant, done, tx_data, tx_start, busy, owner, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART_TX among N_REQ byte requesters.
// Latches the winner's byte, pulses start, then tracks tx_idle to issue grant/done.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned ACCEPT_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES     = 0
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_START       = 3'd1;
  localparam logic [2:0] S_WAIT_ACCEPT = 3'd2;
  localparam logic [2:0] S_WAIT_DONE   = 3'd3;
  localparam logic [2:0] S_GAP         = 3'd4;

  localparam int unsigned CNT_MAX  = (ACCEPT_TIMEOUT > GAP_CYCLES) ? ACCEPT_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ACC_LAST = CW'(ACCEPT_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  logic [2:0]       state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       owner_q, owner_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             tx_start_q, tx_start_d;
  logic             err_q, err_d;

  logic             sel_vld;
  logic [2:0]       sel_idx;
  logic [7:0]       sel_data;
  int unsigned      cand;
  logic [N_REQ-1:0] owner_oh;

  // Search offsets 1..N_REQ from the last served index, so the previous winner ranks lowest.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    cand     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_q) + k) % N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!sel_vld && (i == cand) && bus.req[i]) begin
          sel_vld  = 1'b1;
          sel_idx  = 3'(i);
          sel_data = bus.req_data[8*i +: 8];
        end
      end
    end
  end

  assign owner_oh = N_REQ'(1) << owner_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    grant_d    = '0;
    done_d     = '0;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          owner_d    = sel_idx;
          tx_data_d  = sel_data;
          tx_start_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (!bus.tx_idle) begin
          grant_d = owner_oh;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == ACC_LAST) begin
          // Abandon this attempt; the requester stays pending and rotates like any other.
          err_d   = 1'b1;
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_idle) begin
          done_d = owner_oh;
          last_d = owner_q;
          cnt_d  = '0;
          if (GAP_CYCLES > 0) state_d = S_GAP;
          else                state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_q     <= 3'(N_REQ - 1);
      owner_q    <= '0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.owner       = owner_q;
  assign bus.err_timeout = err_q;

endmodule
